// File: rtl/ctrl_decode_queue_pkg.sv
// Shared opcodes, ALU/memory encodings and the decoded control bundle for ctrl_decode_queue.
// Also holds the legality check used when CTRL_ILLEGAL_CHECK_EN is defined.
package ctrl_decode_queue_pkg;

    // Full 7-bit major opcodes: instr[6:2] plus the mandatory 2'b11 of 32-bit encodings.
    localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
    localparam logic [6:0] OPCODE_ARITH_R = 7'b0110011;
    localparam logic [6:0] OPCODE_ARITH_I = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_LB      = 3'b000;
    localparam logic [2:0] F3_LH      = 3'b001;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_LBU     = 3'b100;
    localparam logic [2:0] F3_LHU     = 3'b101;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_OTHER = 2'b10,
        ALUOP_PASS  = 2'b11
    } alu_op_e;

    // One-hot access size; zero means no memory access.
    localparam logic [2:0] MEM_NONE = 3'b000;
    localparam logic [2:0] MEM_B    = 3'b001;
    localparam logic [2:0] MEM_HW   = 3'b010;
    localparam logic [2:0] MEM_W    = 3'b100;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_JAL  = 2'b01;
    localparam logic [1:0] JUMP_JALR = 2'b10;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       branch;
        logic [1:0] jump;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        alu_op_e    alu_op;
        logic [2:0] mem_mode;
        logic       mem_unsigned;
        logic       illegal;
    } ctrl_bundle_t;

    function automatic logic [2:0] mem_mode_from_f3(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return MEM_B;
            2'b01:   return MEM_HW;
            default: return MEM_W;
        endcase
    endfunction

    function automatic logic instr_is_legal(input logic [31:0] instr);
        logic [2:0] f3;
        f3 = instr[14:12];
        case (instr[6:0])
            OPCODE_LOAD:  return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                                 (f3 == F3_LBU) || (f3 == F3_LHU);
            OPCODE_STORE: return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW);
            OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR, OPCODE_ARITH_R,
            OPCODE_ARITH_I, OPCODE_LUI, OPCODE_AUIPC: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode_queue_if.sv
// Fetch-side and execute-side handshake bundle of ctrl_decode_queue.
// master = fetch/execute environment, slave = the decode queue.
interface ctrl_decode_queue_if #(parameter int XLEN = 32);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] pc_out;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            branch;
    logic [1:0]      jump;
    logic            mem_read;
    logic            mem_to_reg;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;
    logic [1:0]      alu_op;
    logic [2:0]      mem_mode;
    logic            mem_unsigned;
    logic            illegal;

    modport master (
        output flush, in_valid, instr, pc_in, out_ready,
        input  in_ready, out_valid, pc_out, rd, rs1, rs2, funct3, branch, jump,
               mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op,
               mem_mode, mem_unsigned, illegal
    );

    modport slave (
        input  flush, in_valid, instr, pc_in, out_ready,
        output in_ready, out_valid, pc_out, rd, rs1, rs2, funct3, branch, jump,
               mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op,
               mem_mode, mem_unsigned, illegal
    );
endinterface

// File: rtl/ctrl_decode_queue_rv_decode_core.sv
// Purely combinational RV32 instruction -> control bundle decoder.
// CTRL_ILLEGAL_CHECK_EN: flag undecodable instructions via the illegal bit.
module rv_decode_core
    import ctrl_decode_queue_pkg::*;
(
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t bundle_o
);

    logic [2:0] f3;
    logic [6:0] f7;
    ctrl_bundle_t b;

    assign f3 = instr_i[14:12];
    assign f7 = instr_i[31:25];

    always_comb begin
        b          = '0;
        b.rd       = instr_i[11:7];
        b.rs1      = instr_i[19:15];
        b.rs2      = instr_i[24:20];
        b.funct3   = f3;
        b.alu_op   = ALUOP_PASS;
        b.mem_mode = MEM_NONE;
        case (instr_i[6:0])
            OPCODE_LOAD: begin
                b.mem_read     = 1'b1;
                b.mem_to_reg   = 1'b1;
                b.alu_src      = 1'b1;
                b.reg_write    = 1'b1;
                b.alu_op       = ALUOP_ADD;
                b.mem_mode     = mem_mode_from_f3(f3);
                b.mem_unsigned = f3[2];
            end
            OPCODE_STORE: begin
                b.mem_write = 1'b1;
                b.alu_src   = 1'b1;
                b.alu_op    = ALUOP_ADD;
                b.mem_mode  = mem_mode_from_f3(f3);
            end
            OPCODE_BRANCH: begin
                b.branch = 1'b1;
                b.alu_op = ALUOP_SUB;
            end
            OPCODE_JAL: begin
                b.jump      = JUMP_JAL;
                b.reg_write = 1'b1;
            end
            OPCODE_JALR: begin
                b.jump      = JUMP_JALR;
                b.reg_write = 1'b1;
                b.alu_src   = 1'b1;
            end
            OPCODE_ARITH_R: begin
                b.reg_write = 1'b1;
                // SUB wins over ADD only for the exact funct7 pattern.
                if (f3 != F3_ADD_SUB)
                    b.alu_op = ALUOP_OTHER;
                else if (f7 == F7_SUB)
                    b.alu_op = ALUOP_SUB;
                else
                    b.alu_op = ALUOP_ADD;
            end
            OPCODE_ARITH_I: begin
                b.reg_write = 1'b1;
                b.alu_src   = 1'b1;
                b.alu_op    = (f3 == F3_ADD_SUB) ? ALUOP_ADD : ALUOP_OTHER;
            end
            OPCODE_LUI, OPCODE_AUIPC: begin
                b.reg_write = 1'b1;
            end
            default: begin
            end
        endcase
`ifdef CTRL_ILLEGAL_CHECK_EN
        if (!instr_is_legal(instr_i)) begin
            b         = '0;
            b.rd      = instr_i[11:7];
            b.rs1     = instr_i[19:15];
            b.rs2     = instr_i[24:20];
            b.illegal = 1'b1;
        end
`endif
    end

    assign bundle_o = b;

endmodule

// File: rtl/ctrl_decode_queue.sv
// Decode stage: decodes at push and queues control bundles in a DEPTH-entry FIFO.
// Illegal-instruction flagging is built in when CTRL_ILLEGAL_CHECK_EN is defined.
module ctrl_decode_queue
    import ctrl_decode_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    ctrl_decode_queue_if.slave  bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    ctrl_bundle_t    dec_bundle;
    ctrl_bundle_t    head_bundle;
    ctrl_bundle_t    bundle_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q [DEPTH];
    logic [XLEN-1:0] head_pc;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_w, out_valid_w, push, pop;

    rv_decode_core u_decode (
        .instr_i  (bus.instr),
        .bundle_o (dec_bundle)
    );

    // Explicit wrap keeps non-power-of-2 depths correct.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign in_ready_w  = (count_q < CNT_FULL);
    assign out_valid_w = (count_q != '0);
    assign push        = bus.in_valid & in_ready_w & ~bus.flush;
    assign pop         = out_valid_w & bus.out_ready & ~bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_next(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            bundle_mem_q[wr_ptr_q] <= dec_bundle;
            pc_mem_q[wr_ptr_q]     <= bus.pc_in;
        end
    end

    assign head_bundle = out_valid_w ? bundle_mem_q[rd_ptr_q] : '0;
    assign head_pc     = out_valid_w ? pc_mem_q[rd_ptr_q] : '0;

    assign bus.in_ready     = in_ready_w;
    assign bus.out_valid    = out_valid_w;
    assign bus.pc_out       = head_pc;
    assign bus.rd           = head_bundle.rd;
    assign bus.rs1          = head_bundle.rs1;
    assign bus.rs2          = head_bundle.rs2;
    assign bus.funct3       = head_bundle.funct3;
    assign bus.branch       = head_bundle.branch;
    assign bus.jump         = head_bundle.jump;
    assign bus.mem_read     = head_bundle.mem_read;
    assign bus.mem_to_reg   = head_bundle.mem_to_reg;
    assign bus.mem_write    = head_bundle.mem_write;
    assign bus.alu_src      = head_bundle.alu_src;
    assign bus.reg_write    = head_bundle.reg_write;
    assign bus.alu_op       = head_bundle.alu_op;
    assign bus.mem_mode     = head_bundle.mem_mode;
    assign bus.mem_unsigned = head_bundle.mem_unsigned;
    assign bus.illegal      = head_bundle.illegal;

endmodule

// File: tb/tb_ctrl_decode_queue.sv
// Self-checking bench for ctrl_decode_queue: decode table, corner sequences on DEPTH=2,
// and a randomized run of DEPTH 1/2/3/8 instances against a queue-based reference.
module tb_ctrl_decode_queue;

`ifdef CTRL_ILLEGAL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic        out_valid;
        logic        in_ready;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        branch;
        logic [1:0]  jump;
        logic        mem_read;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_write;
        logic [1:0]  alu_op;
        logic [2:0]  mem_mode;
        logic        mem_unsigned;
        logic        illegal;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  alu_op;
        logic        reg_write;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic [1:0]  jump;
        logic [2:0]  mem_mode;
        logic        mem_unsigned;
        logic        bad;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        iv   [4];
    logic        ordy [4];
    logic        fl   [4];
    logic [31:0] ins  [4];
    logic [31:0] pcv  [4];
    obs_t        obs  [4];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 8;
        ctrl_decode_queue_if #(.XLEN(32)) bus ();
        ctrl_decode_queue #(.XLEN(32), .DEPTH(D)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign bus.in_valid  = iv[g];
        assign bus.out_ready = ordy[g];
        assign bus.flush     = fl[g];
        assign bus.instr     = ins[g];
        assign bus.pc_in     = pcv[g];
        assign obs[g] = {bus.out_valid, bus.in_ready, bus.pc_out, bus.rd, bus.rs1, bus.rs2,
                         bus.funct3, bus.branch, bus.jump, bus.mem_read, bus.mem_to_reg,
                         bus.mem_write, bus.alu_src, bus.reg_write, bus.alu_op, bus.mem_mode,
                         bus.mem_unsigned, bus.illegal};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    function automatic int dep(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 8;
    endfunction

    function automatic obs_t empty_exp();
        obs_t e;
        e = '0;
        e.in_ready = 1'b1;
        return e;
    endfunction

    // Reference decode written directly from the instruction-class rules.
    function automatic obs_t ref_head(input logic [31:0] x, input logic [31:0] pc, input logic rdy);
        obs_t e;
        logic [6:0] op;
        logic [2:0] f3;
        bit ld, st, br, jl, jr, rr, ii, lu, au, known, bad;
        op = x[6:0];
        f3 = x[14:12];
        ld = (op == 7'h03); st = (op == 7'h23); br = (op == 7'h63);
        jl = (op == 7'h6F); jr = (op == 7'h67); rr = (op == 7'h33);
        ii = (op == 7'h13); lu = (op == 7'h37); au = (op == 7'h17);
        known = ld | st | br | jl | jr | rr | ii | lu | au;
        bad = !known || (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) || (st && (f3 > 3'd2));
        e = '0;
        e.out_valid = 1'b1;
        e.in_ready  = rdy;
        e.pc  = pc;
        e.rd  = x[11:7];
        e.rs1 = x[19:15];
        e.rs2 = x[24:20];
        if (CHK && bad) begin
            e.illegal = 1'b1;
            return e;
        end
        e.funct3     = f3;
        e.branch     = br;
        e.jump       = jl ? 2'd1 : jr ? 2'd2 : 2'd0;
        e.mem_read   = ld;
        e.mem_to_reg = ld;
        e.mem_write  = st;
        e.alu_src    = ii | ld | st | jr;
        e.reg_write  = ld | rr | ii | jl | jr | lu | au;
        if (rr)           e.alu_op = (f3 != 0) ? 2'd2 : (x[31:25] == 7'h20) ? 2'd1 : 2'd0;
        else if (ii)      e.alu_op = (f3 == 0) ? 2'd0 : 2'd2;
        else if (ld | st) e.alu_op = 2'd0;
        else if (br)      e.alu_op = 2'd1;
        else              e.alu_op = 2'd3;
        if (ld | st) e.mem_mode = (f3[1:0] == 2'd0) ? 3'b001 : (f3[1:0] == 2'd1) ? 3'b010 : 3'b100;
        e.mem_unsigned = ld & f3[2];
        return e;
    endfunction

    function automatic obs_t vec_exp(input vec_t v, input logic [31:0] pc);
        obs_t e;
        e = '0;
        e.out_valid = 1'b1;
        e.in_ready  = 1'b1;
        e.pc  = pc;
        e.rd  = v.instr[11:7];
        e.rs1 = v.instr[19:15];
        e.rs2 = v.instr[24:20];
        if (CHK && v.bad) begin
            e.illegal = 1'b1;
            return e;
        end
        e.funct3 = v.instr[14:12];
        e.alu_op = v.alu_op;     e.reg_write = v.reg_write; e.alu_src = v.alu_src;
        e.mem_read = v.mem_read; e.mem_to_reg = v.mem_read; e.mem_write = v.mem_write;
        e.branch = v.branch;     e.jump = v.jump;           e.mem_mode = v.mem_mode;
        e.mem_unsigned = v.mem_unsigned;
        return e;
    endfunction

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    vec_t        vt [18];
    logic [63:0] mq [4][$];

    initial begin
        obs_t e;
        logic [63:0] ent;
        logic [31:0] r;
        bit dpush, dpop;

        //           instr         alu  rw   as   mr   mw   br   jmp  mm      uns  bad
        vt[0]  = '{32'h002081B3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0};
        vt[1]  = '{32'h402081B3, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0};
        vt[2]  = '{32'h0040C183, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'b001, 1'b1, 1'b0};
        vt[3]  = '{32'h008000EF, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'b000, 1'b0, 1'b0};
        vt[4]  = '{32'h000100E7, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'b000, 1'b0, 1'b0};
        vt[5]  = '{32'h123452B7, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0};
        vt[6]  = '{32'h00001297, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0};
        vt[7]  = '{32'h00208463, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'b000, 1'b0, 1'b0};
        vt[8]  = '{32'h0020A223, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'b100, 1'b0, 1'b0};
        vt[9]  = '{32'h00500093, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0};
        vt[10] = '{32'hFFF0C093, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0};
        vt[11] = '{32'h002091B3, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0};
        vt[12] = '{32'h00000000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1};
        vt[13] = '{32'h0000A183, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'b100, 1'b0, 1'b0};
        vt[14] = '{32'h0000B183, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'b100, 1'b0, 1'b1};
        vt[15] = '{32'h0020C223, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'b001, 1'b0, 1'b1};
        vt[16] = '{32'h0000000B, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1};
        vt[17] = '{32'h0040D183, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'b010, 1'b1, 1'b0};

        rst_n = 1'b0;
        for (int g = 0; g < 4; g++) begin
            iv[g] = 1'b0; ordy[g] = 1'b0; fl[g] = 1'b0; ins[g] = '0; pcv[g] = '0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) chk($sformatf("reset_state[%0d]", g), obs[g], empty_exp());
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset", obs[1], empty_exp());

        // Decode table: one instruction per cycle, consumed the cycle after it appears.
        ordy[1] = 1'b1;
        for (int i = 0; i < 18; i++) begin
            iv[1] = 1'b1; ins[1] = vt[i].instr; pcv[1] = 32'h1000 + 32'(4 * i);
            @(negedge clk);
            chk($sformatf("decode[%0d]", i), obs[1], vec_exp(vt[i], 32'h1000 + 32'(4 * i)));
        end
        iv[1] = 1'b0;
        @(negedge clk);
        chk("empty_after_pop", obs[1], empty_exp());

        // Back-pressure: third instruction waits for space, all three drain in order.
        ordy[1] = 1'b0;
        iv[1] = 1'b1; ins[1] = vt[0].instr; pcv[1] = 32'h0;
        @(negedge clk); chk("fill1", obs[1], ref_head(vt[0].instr, 32'h0, 1'b1));
        ins[1] = vt[1].instr; pcv[1] = 32'h4;
        @(negedge clk); chk("fill2", obs[1], ref_head(vt[0].instr, 32'h0, 1'b0));
        ins[1] = vt[2].instr; pcv[1] = 32'h8;
        @(negedge clk); chk("held", obs[1], ref_head(vt[0].instr, 32'h0, 1'b0));
        ordy[1] = 1'b1;
        @(negedge clk); chk("drain1", obs[1], ref_head(vt[1].instr, 32'h4, 1'b1));
        @(negedge clk); iv[1] = 1'b0;
        chk("drain2", obs[1], ref_head(vt[2].instr, 32'h8, 1'b1));
        @(negedge clk); chk("drain3", obs[1], empty_exp());

        // Flush of a full queue with a simultaneous push offer.
        ordy[1] = 1'b0;
        iv[1] = 1'b1; ins[1] = vt[3].instr; pcv[1] = 32'h10;
        @(negedge clk); ins[1] = vt[4].instr; pcv[1] = 32'h14;
        @(negedge clk); chk("full", obs[1], ref_head(vt[3].instr, 32'h10, 1'b0));
        fl[1] = 1'b1; ordy[1] = 1'b1; ins[1] = vt[5].instr; pcv[1] = 32'h18;
        @(negedge clk); fl[1] = 1'b0; iv[1] = 1'b0;
        chk("flush1", obs[1], empty_exp());
        @(negedge clk); chk("flush2", obs[1], empty_exp());

        // Asynchronous reset with an entry in flight.
        ordy[1] = 1'b0;
        iv[1] = 1'b1; ins[1] = vt[7].instr; pcv[1] = 32'h20;
        @(negedge clk); iv[1] = 1'b0;
        chk("pre_reset", obs[1], ref_head(vt[7].instr, 32'h20, 1'b1));
        #2 rst_n = 1'b0;
        #1 chk("async_reset", obs[1], empty_exp());
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); chk("post_reset", obs[1], empty_exp());

        // Randomized traffic on all depths against per-instance reference queues.
        for (int c = 0; c < 10000; c++) begin
            for (int g = 0; g < 4; g++) begin
                if (mq[g].size() == 0) e = empty_exp();
                else begin
                    ent = mq[g][0];
                    e = ref_head(ent[63:32], ent[31:0], 1'(mq[g].size() < dep(g)));
                end
                chk($sformatf("rand_d%0d_c%0d", dep(g), c), obs[g], e);
                iv[g]   = ($urandom_range(0, 9) < 6);
                ordy[g] = ($urandom_range(0, 9) < 6);
                fl[g]   = ($urandom_range(0, 99) < 3);
                r = $urandom;
                if ($urandom_range(0, 1) == 0) r = vt[$urandom_range(0, 17)].instr;
                else if ($urandom_range(0, 3) != 0) r[1:0] = 2'b11;
                ins[g] = r;
                pcv[g] = $urandom;
                dpush = iv[g] && (mq[g].size() < dep(g)) && !fl[g];
                dpop  = (mq[g].size() != 0) && ordy[g] && !fl[g];
                if (fl[g]) mq[g].delete();
                else begin
                    if (dpop)  ent = mq[g].pop_front();
                    if (dpush) mq[g].push_back({ins[g], pcv[g]});
                end
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
